// File: rtl/gray_pkg.sv
// gray_pkg: shared types, fault cause codes and Gray-to-binary helper for the
// gray_checker protocol monitor.
//   state_t   : checker FSM states (SYNC, TRACK, FAULT)
//   ERR_*     : 2-bit fault cause codes reported on ErrCode
//   gray2bin  : Gray -> binary conversion for any width up to GRAY_MAX_W
package gray_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_MULTI = 2'b01;
  localparam logic [1:0] ERR_BACK  = 2'b10;
  localparam logic [1:0] ERR_OVF   = 2'b11;

  localparam int unsigned GRAY_MAX_W = 32;

  // Each binary bit is the XOR of all Gray bits at or above it. The
  // shift-doubling prefix XOR builds that in log2 steps without per-bit
  // indexing. Bits at or above w are masked off first.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(
    input logic [GRAY_MAX_W-1:0] g,
    input int unsigned           w
  );
    logic [GRAY_MAX_W-1:0] mask;
    logic [GRAY_MAX_W-1:0] b;
    mask = (w >= GRAY_MAX_W) ? '1 : ((GRAY_MAX_W'(1) << w) - GRAY_MAX_W'(1));
    b    = g & mask;
    for (int unsigned s = 1; s < GRAY_MAX_W; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_checker_gray_to_bin.sv
// gray_to_bin: purely combinational Gray -> binary converter.
//   i_gray : WIDTH-bit Gray code input
//   o_bin  : WIDTH-bit binary equivalent
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  always_comb begin
    o_bin = WIDTH'(gray2bin(GRAY_MAX_W'(i_gray), WIDTH));
  end

endmodule

// File: rtl/gray_checker.sv
// gray_checker: live protocol monitor for an upstream Gray counter.
// Samples Gray/Overflow every rising edge, tracks the binary value, counts
// forward steps and max->0 wraps (both saturating), and latches a sticky
// fault with a cause code on any illegal change or overflow inconsistency.
//   Clk      : system clock
//   Reset    : synchronous, active-high; clears everything back to SYNC
//   Gray     : Gray code from the upstream counter
//   Overflow : upstream sticky overflow flag
//   Bin      : binary value of the last accepted sample
//   Steps    : valid forward steps since reset (saturating)
//   Wraps    : max->0 wraps since reset (saturating)
//   Error    : sticky fault flag
//   ErrCode  : fault cause (ERR_NONE/ERR_MULTI/ERR_BACK/ERR_OVF)
module gray_checker
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Gray,
  input  logic             Overflow,
  output logic [WIDTH-1:0] Bin,
  output logic [CNT_W-1:0] Steps,
  output logic [CNT_W-1:0] Wraps,
  output logic             Error,
  output logic [1:0]       ErrCode
);

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_prev, w_prev;
  logic             r_ovf_prev, w_ovf_prev;
  logic [WIDTH-1:0] r_bin, w_bin;
  logic [CNT_W-1:0] r_steps, w_steps;
  logic [CNT_W-1:0] r_wraps, w_wraps;
  logic             r_err, w_err;
  logic [1:0]       r_code, w_code;

  logic [WIDTH-1:0] w_bin_cur;
  logic [WIDTH-1:0] w_bin_prev;
  logic [WIDTH-1:0] w_diff;
  logic             w_change;
  logic             w_single;
  logic             w_multi;
  logic             w_fwd;
  logic             w_wrap;
  logic             w_ovf_bad;

  gray_to_bin #(.WIDTH(WIDTH)) u_cur_g2b (
    .i_gray (Gray),
    .o_bin  (w_bin_cur)
  );

  gray_to_bin #(.WIDTH(WIDTH)) u_prev_g2b (
    .i_gray (r_prev),
    .o_bin  (w_bin_prev)
  );

  always_comb begin
    w_diff    = Gray ^ r_prev;
    w_change  = (w_diff != '0);
    w_single  = $onehot(w_diff);
    w_multi   = w_change && !w_single;
    w_fwd     = w_single && (w_bin_cur == (w_bin_prev + WIDTH'(1)));
    w_wrap    = w_fwd && (w_bin_prev == '1);
    // A wrap on this very edge legitimises a rising Overflow.
    w_ovf_bad = (Overflow && (r_wraps == '0) && !w_wrap) ||
                (r_ovf_prev && !Overflow);
  end

  always_comb begin
    w_state    = r_state;
    w_prev     = r_prev;
    w_ovf_prev = r_ovf_prev;
    w_bin      = r_bin;
    w_steps    = r_steps;
    w_wraps    = r_wraps;
    w_err      = r_err;
    w_code     = r_code;

    unique case (r_state)
      SYNC: begin
        w_prev     = Gray;
        w_bin      = w_bin_cur;
        w_ovf_prev = Overflow;
        w_state    = TRACK;
      end

      TRACK: begin
        w_ovf_prev = Overflow;
        // Fault priority: multi-bit, then backward/illegal, then overflow.
        if (w_multi) begin
          w_state = FAULT;
          w_err   = 1'b1;
          w_code  = ERR_MULTI;
        end else if (w_single && !w_fwd) begin
          w_state = FAULT;
          w_err   = 1'b1;
          w_code  = ERR_BACK;
        end else if (w_ovf_bad) begin
          w_state = FAULT;
          w_err   = 1'b1;
          w_code  = ERR_OVF;
        end else if (w_fwd) begin
          w_prev = Gray;
          w_bin  = w_bin_cur;
          if (r_steps != '1) w_steps = r_steps + CNT_W'(1);
          if (w_wrap && (r_wraps != '1)) w_wraps = r_wraps + CNT_W'(1);
        end
      end

      FAULT: begin
      end

      default: begin
        w_state = SYNC;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= SYNC;
      r_prev     <= '0;
      r_ovf_prev <= 1'b0;
      r_bin      <= '0;
      r_steps    <= '0;
      r_wraps    <= '0;
      r_err      <= 1'b0;
      r_code     <= ERR_NONE;
    end else begin
      r_state    <= w_state;
      r_prev     <= w_prev;
      r_ovf_prev <= w_ovf_prev;
      r_bin      <= w_bin;
      r_steps    <= w_steps;
      r_wraps    <= w_wraps;
      r_err      <= w_err;
      r_code     <= w_code;
    end
  end

  assign Bin     = r_bin;
  assign Steps   = r_steps;
  assign Wraps   = r_wraps;
  assign Error   = r_err;
  assign ErrCode = r_code;

endmodule

// File: tb/tb_gray_checker.sv
// Bench for gray_checker (WIDTH=3, CNT_W=8). A behavioural reference model,
// written from Gray encoding rather than decoding, pushes expected outputs
// into a scoreboard queue as stimulus is driven; each scenario task pops and
// compares them against the sampled DUT outputs, plus fixed-value checks.
module tb_gray_checker;

  localparam int unsigned W  = 3;
  localparam int unsigned CW = 8;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic [W-1:0]  Gray = '0;
  logic          Overflow = 1'b0;
  logic [W-1:0]  Bin;
  logic [CW-1:0] Steps;
  logic [CW-1:0] Wraps;
  logic          Error;
  logic [1:0]    ErrCode;

  gray_checker #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Gray     (Gray),
    .Overflow (Overflow),
    .Bin      (Bin),
    .Steps    (Steps),
    .Wraps    (Wraps),
    .Error    (Error),
    .ErrCode  (ErrCode)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0] bin;
    logic [7:0] steps;
    logic [7:0] wraps;
    logic       err;
    logic [1:0] code;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: 0=sync, 1=track, 2=fault
  int         m_state = 0;
  logic [2:0] m_prev = '0;
  logic [2:0] m_pbin = '0;
  logic       m_ovfp = 1'b0;
  logic [2:0] m_bin = '0;
  logic [7:0] m_steps = '0;
  logic [7:0] m_wraps = '0;
  logic       m_err = 1'b0;
  logic [1:0] m_code = '0;

  function automatic logic [2:0] b2g(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [2:0] g2b(input logic [2:0] g);
    for (int k = 0; k < 8; k++) if (b2g(3'(k)) == g) return 3'(k);
    return 3'd0;
  endfunction

  task automatic model_step(input logic [2:0] g, input logic ovf, input logic rst);
    logic [2:0] nxt_b, nxt_g;
    logic       wrapnow, ovfbad;
    logic [1:0] code;
    if (rst) begin
      m_state = 0; m_prev = '0; m_pbin = '0; m_ovfp = 1'b0;
      m_bin = '0; m_steps = '0; m_wraps = '0; m_err = 1'b0; m_code = '0;
    end else if (m_state == 0) begin
      m_prev = g; m_pbin = g2b(g); m_bin = m_pbin; m_ovfp = ovf; m_state = 1;
    end else if (m_state == 1) begin
      nxt_b   = m_pbin + 3'd1;
      nxt_g   = b2g(nxt_b);
      wrapnow = (g == nxt_g) && (m_pbin == 3'd7);
      ovfbad  = (ovf && (m_wraps == 0) && !wrapnow) || (m_ovfp && !ovf);
      code    = 2'b00;
      if (g != m_prev && g != nxt_g) code = ($countones(g ^ m_prev) > 1) ? 2'b01 : 2'b10;
      if (code == 2'b00 && ovfbad) code = 2'b11;
      if (code != 2'b00) begin
        m_state = 2; m_err = 1'b1; m_code = code;
      end else if (g == nxt_g) begin
        m_prev = g; m_pbin = nxt_b; m_bin = nxt_b;
        if (m_steps != 8'hFF) m_steps++;
        if (wrapnow && m_wraps != 8'hFF) m_wraps++;
      end
      m_ovfp = ovf;
    end
  endtask

  task automatic cyc(input logic [2:0] g, input logic ovf, input logic rst);
    @(negedge Clk);
    Gray = g; Overflow = ovf; Reset = rst;
    model_step(g, ovf, rst);
    exp_q.push_back('{m_bin, m_steps, m_wraps, m_err, m_code});
    @(posedge Clk);
    #1;
    obs_q.push_back('{Bin, Steps, Wraps, Error, ErrCode});
  endtask

  task automatic test_reset_and_steps();
    obs_t e, o;
    cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b000, 1'b0, 1'b1);
    n_tests++;
    if ({Bin, Steps, Wraps, Error, ErrCode} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=0", {Bin, Steps, Wraps, Error, ErrCode});
    end
    cyc(3'b000, 1'b0, 1'b0);
    cyc(3'b001, 1'b0, 1'b0);
    cyc(3'b011, 1'b0, 1'b0);
    cyc(3'b010, 1'b0, 1'b0);
    cyc(3'b110, 1'b0, 1'b0);
    n_tests++;
    if (Bin !== 3'd4 || Steps !== 8'd4 || Wraps !== 8'd0 || Error !== 1'b0) begin
      n_fail++;
      $display("FAIL steps4 got bin=%0d steps=%0d wraps=%0d err=%b want 4/4/0/0", Bin, Steps, Wraps, Error);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL sb_steps got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_hold();
    obs_t e, o;
    for (int i = 0; i < 3; i++) cyc(3'b110, 1'b0, 1'b0);
    n_tests++;
    if (Bin !== 3'd4 || Steps !== 8'd4 || Error !== 1'b0) begin
      n_fail++;
      $display("FAIL hold got bin=%0d steps=%0d err=%b want 4/4/0", Bin, Steps, Error);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL sb_hold got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_wrap();
    obs_t e, o;
    cyc(3'b111, 1'b0, 1'b0);
    cyc(3'b101, 1'b0, 1'b0);
    cyc(3'b100, 1'b0, 1'b0);
    cyc(3'b000, 1'b1, 1'b0);
    n_tests++;
    if (Wraps !== 8'd1 || Steps !== 8'd8 || Bin !== 3'd0 || Error !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap got wraps=%0d steps=%0d bin=%0d err=%b want 1/8/0/0", Wraps, Steps, Bin, Error);
    end
    cyc(3'b000, 1'b1, 1'b0);
    cyc(3'b001, 1'b1, 1'b0);
    n_tests++;
    if (Error !== 1'b0 || Steps !== 8'd9) begin
      n_fail++;
      $display("FAIL ovf_held got err=%b steps=%0d want 0/9", Error, Steps);
    end
    // Overflow dropping without reset is an inconsistency
    cyc(3'b011, 1'b0, 1'b0);
    n_tests++;
    if (Error !== 1'b1 || ErrCode !== 2'b11 || Steps !== 8'd9 || Bin !== 3'd1) begin
      n_fail++;
      $display("FAIL ovf_fall got err=%b code=%b steps=%0d bin=%0d want 1/11/9/1", Error, ErrCode, Steps, Bin);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL sb_wrap got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_multi();
    obs_t e, o;
    cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b000, 1'b0, 1'b0);
    cyc(3'b011, 1'b0, 1'b0);
    n_tests++;
    if (Error !== 1'b1 || ErrCode !== 2'b01 || Bin !== 3'd0 || Steps !== 8'd0) begin
      n_fail++;
      $display("FAIL multi got err=%b code=%b bin=%0d steps=%0d want 1/01/0/0", Error, ErrCode, Bin, Steps);
    end
    cyc(3'b001, 1'b0, 1'b0);
    n_tests++;
    if (Error !== 1'b1 || ErrCode !== 2'b01 || Steps !== 8'd0) begin
      n_fail++;
      $display("FAIL frozen got err=%b code=%b steps=%0d want 1/01/0", Error, ErrCode, Steps);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL sb_multi got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_back_and_ovf();
    obs_t e, o;
    cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b000, 1'b0, 1'b0);
    cyc(3'b001, 1'b0, 1'b0);
    cyc(3'b000, 1'b0, 1'b0);
    n_tests++;
    if (ErrCode !== 2'b10 || Error !== 1'b1 || Bin !== 3'd1 || Steps !== 8'd1) begin
      n_fail++;
      $display("FAIL back got code=%b err=%b bin=%0d steps=%0d want 10/1/1/1", ErrCode, Error, Bin, Steps);
    end
    cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b000, 1'b0, 1'b0);
    cyc(3'b001, 1'b1, 1'b0);
    n_tests++;
    if (ErrCode !== 2'b11 || Error !== 1'b1 || Steps !== 8'd0) begin
      n_fail++;
      $display("FAIL ovf_early got code=%b err=%b steps=%0d want 11/1/0", ErrCode, Error, Steps);
    end
    // Priority: multi-bit beats overflow
    cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b000, 1'b0, 1'b0);
    cyc(3'b011, 1'b1, 1'b0);
    n_tests++;
    if (ErrCode !== 2'b01) begin
      n_fail++;
      $display("FAIL prio_multi got code=%b want 01", ErrCode);
    end
    // Priority: backward beats overflow
    cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b000, 1'b0, 1'b0);
    cyc(3'b001, 1'b0, 1'b0);
    cyc(3'b000, 1'b1, 1'b0);
    n_tests++;
    if (ErrCode !== 2'b10) begin
      n_fail++;
      $display("FAIL prio_back got code=%b want 10", ErrCode);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL sb_back got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_reset_from_fault_and_saturate();
    obs_t e, o;
    cyc(3'b010, 1'b1, 1'b1);
    n_tests++;
    if ({Bin, Steps, Wraps, Error, ErrCode} !== '0) begin
      n_fail++;
      $display("FAIL fault_reset got=%h want=0", {Bin, Steps, Wraps, Error, ErrCode});
    end
    cyc(3'b000, 1'b0, 1'b0);
    for (int i = 1; i <= 260; i++) cyc(b2g(3'(i % 8)), (i >= 8), 1'b0);
    n_tests++;
    if (Steps !== 8'd255 || Wraps !== 8'd32 || Error !== 1'b0 || Bin !== 3'd4) begin
      n_fail++;
      $display("FAIL saturate got steps=%0d wraps=%0d err=%b bin=%0d want 255/32/0/4", Steps, Wraps, Error, Bin);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL sb_sat got=%h want=%h", o, e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset_and_steps();
    test_hold();
    test_wrap();
    test_multi();
    test_back_and_ovf();
    test_reset_from_fault_and_saturate();
    n_tests++;
    if (exp_q.size() != obs_q.size()) begin
      n_fail++;
      $display("FAIL sb_drain got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
